// File: rtl/sync_down_cnt_pkg.sv
// Shared types for the loadable synchronous down counter.
// State encoding and default counter width.
package sync_down_cnt_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/sync_down_counter.sv
// Loadable, enable-gated down counter with registered terminal-count pulse.
// SYNC_DOWN_CNT_RELOAD_EN: periodic mode, reloads the last loaded value at terminal count.
module sync_down_counter
  import sync_down_cnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             last;

  assign last = (count_q == WIDTH'(1));

`ifdef SYNC_DOWN_CNT_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reload_q <= '0;
    end else if (!clear && load) begin
      reload_q <= load_value;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
      state_d = (load_value != '0) ? ST_COUNT : ST_IDLE;
    end else if (state_q == ST_COUNT && enable) begin
      if (last) begin
        tc_d = 1'b1;
`ifdef SYNC_DOWN_CNT_RELOAD_EN
        count_d = reload_q;
`else
        count_d = '0;
        state_d = ST_EXPIRED;
`endif
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == ST_COUNT);
`ifdef SYNC_DOWN_CNT_RELOAD_EN
  assign done  = 1'b0;
`else
  assign done  = (state_q == ST_EXPIRED);
`endif

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed-vector bench for sync_down_counter.
// Covers one-shot mode by default, periodic mode with SYNC_DOWN_CNT_RELOAD_EN.
module tb_sync_down_counter;

  localparam int W = 4;

  logic         clock;
  logic         reset_n;
  logic         clear;
  logic         load;
  logic [W-1:0] load_value;
  logic         enable;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         clr;
    logic         ld;
    logic [W-1:0] lv;
    logic         en;
    logic [W-1:0] c;
    logic         t;
    logic         b;
    logic         d;
  } vec_t;

  vec_t vecs[$];

  sync_down_counter #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic clr, input logic ld,
                     input logic [W-1:0] lv, input logic en,
                     input logic [W-1:0] c, input logic t,
                     input logic b, input logic d);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.en = en;
    v.c = c; v.t = t; v.b = b; v.d = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] c,
                       input logic t, input logic b, input logic d);
    checks++;
    if ({count, tc, busy, done} !== {c, t, b, d}) begin
      failures++;
      $display("FAIL %s: got count=%0d tc=%0b busy=%0b done=%0b want count=%0d tc=%0b busy=%0b done=%0b",
               name, count, tc, busy, done, c, t, b, d);
    end
  endtask

  task automatic step(input logic clr, input logic ld,
                      input logic [W-1:0] lv, input logic en);
    @(negedge clock);
    clear = clr; load = ld; load_value = lv; enable = en;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; load = 1'b0;
    load_value = '0; enable = 1'b0;
    #12;
    check("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

`ifndef SYNC_DOWN_CNT_RELOAD_EN
    // one-shot from 3
    add(0, 1, 4'd3, 0, 4'd3, 0, 1, 0);
    add(0, 0, 4'd0, 1, 4'd2, 0, 1, 0);
    add(0, 0, 4'd0, 1, 4'd1, 0, 1, 0);
    add(0, 0, 4'd0, 1, 4'd0, 1, 0, 1);
    add(0, 0, 4'd0, 1, 4'd0, 0, 0, 1);
    // enable gating from 2
    add(0, 1, 4'd2, 0, 4'd2, 0, 1, 0);
    add(0, 0, 4'd0, 1, 4'd1, 0, 1, 0);
    add(0, 0, 4'd0, 0, 4'd1, 0, 1, 0);
    add(0, 0, 4'd0, 0, 4'd1, 0, 1, 0);
    add(0, 0, 4'd0, 1, 4'd0, 1, 0, 1);
    add(1, 0, 4'd0, 0, 4'd0, 0, 0, 0);
    add(0, 0, 4'd0, 1, 4'd0, 0, 0, 0);
    // load beats enable, reload at terminal cycle
    add(0, 1, 4'd2, 1, 4'd2, 0, 1, 0);
    add(0, 0, 4'd0, 1, 4'd1, 0, 1, 0);
    add(0, 1, 4'd5, 1, 4'd5, 0, 1, 0);
    add(0, 0, 4'd0, 1, 4'd4, 0, 1, 0);
    add(1, 1, 4'd7, 1, 4'd0, 0, 0, 0);
    // zero load
    add(0, 1, 4'd0, 1, 4'd0, 0, 0, 0);
    add(0, 0, 4'd0, 1, 4'd0, 0, 0, 0);
    // max value, then zero load mid-count
    add(0, 1, 4'd15, 0, 4'd15, 0, 1, 0);
    add(0, 0, 4'd0, 1, 4'd14, 0, 1, 0);
    add(0, 1, 4'd0, 1, 4'd0, 0, 0, 0);
    add(0, 0, 4'd0, 1, 4'd0, 0, 0, 0);
    // single-cycle count from 1
    add(0, 1, 4'd1, 0, 4'd1, 0, 1, 0);
    add(0, 0, 4'd0, 1, 4'd0, 1, 0, 1);
    // load out of expired
    add(0, 1, 4'd4, 0, 4'd4, 0, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en);
      check($sformatf("vec%0d", i), vecs[i].c, vecs[i].t, vecs[i].b, vecs[i].d);
    end
`else
    step(0, 1, 4'd3, 0);
    check("reload_load", 4'd3, 0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 4'd0, 1);
      check($sformatf("reload_cyc%0d", i),
            (i % 3 == 0) ? 4'd3 : W'(3 - (i % 3)),
            (i % 3 == 0), 1'b1, 1'b0);
    end
    step(0, 0, 4'd0, 0);
    check("reload_hold", 4'd2, 0, 1, 0);
`endif

    // async reset mid-count at count 5
    step(0, 1, 4'd6, 0);
    step(0, 0, 4'd0, 1);
    check("pre_reset", 4'd5, 0, 1, 0);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 4'd0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step(0, 0, 4'd0, 1);
    check("post_reset_idle", 4'd0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
